// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop synchronizer, framing-error pulse and sticky overrun.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote at every sample point.
module uart_rx #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] dout,
   output logic       dout_valid,
   input  logic       dout_ack,
   output logic       frame_err,
   output logic       overrun
);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   // Last counter value of each phase: the decision point. The voted build decides one cycle
   // later so that its centre vote lines up with the single-sample point.
`ifdef UART_RX_MAJORITY_EN
   localparam logic [13:0] START_LAST = 14'(HALF_BIT - 2);
`else
   localparam logic [13:0] START_LAST = 14'(HALF_BIT - 3);
`endif
   localparam logic [13:0] BIT_LAST = 14'(CLKS_PER_BIT - 1);

   state_t      state, state_n;
   logic        sync1, rxd_s, rxd_prev;
   logic [1:0]  sync_fill;
   logic [13:0] cnt, phase_last;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        deliver;
   logic        sample, at_last, start_fall;
   logic        cnt_clr, shift_en, good_stop, bad_stop;

   assign phase_last = (state == START) ? START_LAST : BIT_LAST;
   assign at_last    = (cnt == phase_last);
   // rxd_prev only tracks the line once the synchronizer holds real samples, so a line
   // held low across reset never looks like a fresh start edge.
   assign start_fall = !rxd_s && rxd_prev;

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] vote;

   always_ff @(posedge clk) begin
      if (reset) begin
         vote <= 2'b11;
      end else begin
         if (cnt == phase_last - 14'd2) vote[1] <= rxd_s;
         if (cnt == phase_last - 14'd1) vote[0] <= rxd_s;
      end
   end

   assign sample = (vote[1] & vote[0]) | (vote[1] & rxd_s) | (vote[0] & rxd_s);
`else
   assign sample = rxd_s;
`endif

   // NOTE: every output of a combinational block gets a default first; a path that skips
   // an assignment would otherwise infer a latch.
   always_comb begin
      state_n   = state;
      cnt_clr   = 1'b0;
      shift_en  = 1'b0;
      good_stop = 1'b0;
      bad_stop  = 1'b0;
      case (state)
         IDLE:  if (start_fall) begin
                   state_n = START;
                   cnt_clr = 1'b1;
                end
         START: if (at_last) begin
                   cnt_clr = 1'b1;
                   state_n = sample ? IDLE : DATA;
                end
         DATA:  if (at_last) begin
                   cnt_clr  = 1'b1;
                   shift_en = 1'b1;
                   if (bit_idx == 3'd7) state_n = STOP;
                end
         STOP:  if (at_last) begin
                   cnt_clr = 1'b1;
                   if (sample) begin
                      good_stop = 1'b1;
                      state_n   = IDLE;
                   end else begin
                      bad_stop = 1'b1;
                      state_n  = BREAK;
                   end
                end
         BREAK: if (rxd_s) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1      <= 1'b1;
         rxd_s      <= 1'b1;
         sync_fill  <= 2'b00;
         rxd_prev   <= 1'b0;
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         deliver    <= 1'b0;
         dout       <= 8'h00;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         sync1     <= rxd;
         rxd_s     <= sync1;
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1]) rxd_prev <= rxd_s;

         state <= state_n;
         if (cnt_clr || state == IDLE || state == BREAK) cnt <= '0;
         else                                            cnt <= cnt + 14'd1;

         if (state == START)  bit_idx <= '0;
         else if (shift_en)   bit_idx <= bit_idx + 3'd1;
         if (shift_en) shreg <= {sample, shreg[7:1]};

         frame_err <= bad_stop;
         deliver   <= good_stop;

         // An ack in the delivery cycle frees the holding register for the new byte.
         if (deliver) begin
            if (!dout_valid || dout_ack) begin
               dout       <= shreg;
               dout_valid <= 1'b1;
               overrun    <= 1'b0;
            end else begin
               overrun <= 1'b1;
            end
         end else if (dout_ack && dout_valid) begin
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames checked against a frame-level model of the receiver.
module tb_uart_rx;
   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int LAT = 3 + HALF + 9 * CPB;
   localparam bit MAJ = 1'b1;
`else
   localparam int LAT = 2 + HALF + 9 * CPB;
   localparam bit MAJ = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, rxd, dout_ack;
   logic [7:0] dout;
   logic       dout_valid, frame_err, overrun;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, rise_cyc = -1, ferr_cnt = 0;
   logic valid_d = 1'b0;

   // Frame-level reference model
   logic [7:0] m_dout;
   logic       m_valid, m_ovr;
   int         m_ferr = 0;

   uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
      .clk(clk), .reset(reset), .rxd(rxd), .dout(dout), .dout_valid(dout_valid),
      .dout_ack(dout_ack), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (dout_valid && !valid_d) rise_cyc = cyc;
      valid_d = dout_valid;
      if (frame_err) ferr_cnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_dout  = 8'h00;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] b, input logic stop_val, input bit ack_same);
      if (!stop_val)                 m_ferr++;
      else if (!m_valid || ack_same) begin m_dout = b; m_valid = 1'b1; m_ovr = 1'b0; end
      else                           m_ovr = 1'b1;
   endtask

   task automatic ack();
      dout_ack = 1'b1;
      tick();
      dout_ack = 1'b0;
      if (m_valid) begin m_valid = 1'b0; m_ovr = 1'b0; end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_dout"},  32'(dout),       32'(m_dout));
      check({tag, "_valid"}, 32'(dout_valid), 32'(m_valid));
      check({tag, "_ovr"},   32'(overrun),    32'(m_ovr));
      check({tag, "_ferr"},  32'(ferr_cnt),   32'(m_ferr));
   endtask

   // Drives one 10-bit frame; bit n occupies CPB cycles. Optional one-cycle glitch at the
   // bit-0 sample point, ack pulse at offset ack_at, reset pulse at offset rst_at.
   task automatic send_frame(input logic [7:0] b, input logic stop_val, input bit glitch,
                             input int ack_at, input int rst_at, output int k);
      int pos;
      k = cyc;
      rise_cyc = -1;
      for (int j = 0; j < 10 * CPB; j++) begin
         pos = j / CPB;
         if (pos == 0)      rxd = 1'b0;
         else if (pos <= 8) rxd = b[pos-1];
         else               rxd = stop_val;
         if (glitch && j == HALF + CPB - 2) rxd = 1'b0;
         if (j == ack_at)     dout_ack = 1'b1;
         if (j == ack_at + 1) dout_ack = 1'b0;
         if (j == rst_at)     reset = 1'b1;
         if (j == rst_at + 3) reset = 1'b0;
         tick();
      end
      dout_ack = 1'b0;
   endtask

   initial begin
      int k;
      logic [7:0] b;
      bit was_valid;

      reset = 1'b1; rxd = 1'b1; dout_ack = 1'b0;
      model_reset();
      idle(4);
      reset = 1'b0;
      tick();
      check("rst_dout", 32'(dout), 32'h00);
      check("rst_valid", 32'(dout_valid), 32'h0);
      check("rst_ovr", 32'(overrun), 32'h0);
      check("rst_ferr", 32'(frame_err), 32'h0);

      // Single frame, latency and ack
      send_frame(8'hA5, 1'b1, 1'b0, -1, -1, k);
      model_frame(8'hA5, 1'b1, 1'b0);
      check_model("a5");
      check("a5_latency", 32'(rise_cyc - k), 32'(LAT));
      ack();
      check("a5_ack_valid", 32'(dout_valid), 32'h0);
      ack();
      check("idle_ack_dout", 32'(dout), 32'hA5);
      check("idle_ack_valid", 32'(dout_valid), 32'h0);

      // False start: short low pulse must not produce any output
      rxd = 1'b0; idle(HALF / 2); rxd = 1'b1; idle(3 * CPB);
      check_model("false_start");

      // Framing error, line held low, then a good frame
      send_frame(8'h3C, 1'b0, 1'b0, -1, -1, k);
      model_frame(8'h3C, 1'b0, 1'b0);
      rxd = 1'b0; idle(20 * CPB); rxd = 1'b1; idle(2 * CPB);
      check_model("ferr");
      send_frame(8'h55, 1'b1, 1'b0, -1, -1, k);
      model_frame(8'h55, 1'b1, 1'b0);
      check_model("after_break");
      check("after_break_latency", 32'(rise_cyc - k), 32'(LAT));
      ack();

      // Overrun
      send_frame(8'h11, 1'b1, 1'b0, -1, -1, k);
      model_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, -1, -1, k);
      model_frame(8'h22, 1'b1, 1'b0);
      check_model("overrun");
      ack();
      check_model("overrun_ack");

      // Ack coinciding with delivery while an overrun is pending
      send_frame(8'h33, 1'b1, 1'b0, -1, -1, k);
      model_frame(8'h33, 1'b1, 1'b0);
      send_frame(8'h66, 1'b1, 1'b0, -1, -1, k);
      model_frame(8'h66, 1'b1, 1'b0);
      send_frame(8'h44, 1'b1, 1'b0, LAT - 1, -1, k);
      model_frame(8'h44, 1'b1, 1'b1);
      check_model("ack_same");
      ack();

      // Reset during data bit 4, then a fresh frame
      send_frame(8'hFF, 1'b1, 1'b0, -1, 5 * CPB + CPB / 2, k);
      model_reset();
      check_model("rst_mid");
      send_frame(8'h0F, 1'b1, 1'b0, -1, -1, k);
      model_frame(8'h0F, 1'b1, 1'b0);
      check_model("post_rst");
      check("post_rst_latency", 32'(rise_cyc - k), 32'(LAT));
      ack();

      // Line held low across reset must not start a frame
      rxd = 1'b0; idle(CPB);
      reset = 1'b1; idle(2); reset = 1'b0;
      idle(3 * CPB); rxd = 1'b1; idle(12 * CPB);
      model_reset();
      check_model("low_rst");

      // Glitch at the bit-0 sample point
      send_frame(8'h01, 1'b1, 1'b1, -1, -1, k);
      model_frame(MAJ ? 8'h01 : 8'h00, 1'b1, 1'b0);
      check_model("glitch");
      ack();

      // Random frames with random acknowledges
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         was_valid = m_valid;
         idle(int'($urandom_range(0, CPB)));
         send_frame(b, 1'b1, 1'b0, -1, -1, k);
         model_frame(b, 1'b1, 1'b0);
         check_model("rand");
         if (!was_valid) check("rand_latency", 32'(rise_cyc - k), 32'(LAT));
         if ($urandom_range(0, 1) == 1) ack();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 10416, clock cycles per bit (100 MHz / 9600 baud); SHALL be >= 16.
- REQ-002: Parameter HALF_BIT, default CLKS_PER_BIT/2 (5208), cycles from start-bit falling edge to start-bit centre.
- REQ-003: clk  input  1  single system clock; all logic SHALL be on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: rxd  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
- REQ-006: dout  output  8  last correctly framed received byte.
- REQ-007: dout_valid  output  1  high while dout holds an unacknowledged byte.
- REQ-008: dout_ack  input  1  consumer acknowledge; clears dout_valid.
- REQ-009: frame_err  output  1  one-cycle pulse when a stop bit samples low.
- REQ-010: overrun  output  1  sticky; a byte was dropped because dout_valid was still high.

Function
- REQ-011: rxd SHALL pass through a 2-flop synchronizer (rxd_s) before any use; all timing below counts from rxd_s.
- REQ-012: FSM states: IDLE, START, DATA, STOP, BREAK.
- REQ-013: IDLE -> START when rxd_s = 0 (1->0 transition); the bit counter (14 bits) SHALL clear on entry.
- REQ-014: START: after HALF_BIT cycles, sample the line; 0 -> DATA with the counter cleared; 1 -> IDLE (false start, no output activity).
- REQ-015: DATA: sample every CLKS_PER_BIT cycles; shift the sample into bit 7 of an 8-bit shift register (LSB first); after the 8th sample -> STOP.
- REQ-016: STOP: after CLKS_PER_BIT cycles, sample; 1 -> IDLE and deliver the byte; 0 -> assert frame_err for 1 cycle, discard the byte, go to BREAK.
- REQ-017: BREAK -> IDLE only once rxd_s = 1; no start detection while in BREAK.
- REQ-018: Delivery: in the cycle after the stop sample, if dout_valid = 0, load dout and set dout_valid = 1.
- REQ-019: Delivery with dout_valid = 1: dout SHALL be unchanged, the new byte dropped, overrun set.
- REQ-020: dout_ack = 1 SHALL clear dout_valid and overrun on the next edge.
- REQ-021: ack and delivery in the same cycle: the new byte SHALL load, dout_valid SHALL stay 1, and overrun SHALL clear.
- REQ-022: dout_ack while dout_valid = 0 SHALL have no effect.
- REQ-023: Timing: start edge to dout_valid = 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles.

Reset
- REQ-024: Reset SHALL force IDLE, counters 0, dout = 8'h00, dout_valid = 0, frame_err = 0, overrun = 0, and synchronizer flops = 1.
- REQ-025: Reset mid-frame SHALL abandon the frame with no output; the next frame SHALL need a fresh 1->0 edge after reset release.

Configuration
- REQ-026: Macro UART_RX_MAJORITY_EN, when defined, SHALL make every sample point (start, data, stop) a 2-of-3 majority vote over rxd_s at counter values mid-1, mid and mid+1, with the decision taken at mid+1.
- REQ-027: Without the macro, each sample SHALL be the single value of rxd_s at the mid point; the REQ-023 latency then drops by 1 cycle.

Verification
- REQ-028: Frame 0xA5 at CLKS_PER_BIT=10416, no ack -> dout=8'hA5, dout_valid=1 at the REQ-023 cycle; ack -> dout_valid=0 next cycle.
- REQ-029: rxd low for 1000 cycles then high -> FSM back to IDLE after HALF_BIT; dout_valid, frame_err and overrun stay 0.
- REQ-030: Frame 0x3C with stop bit 0, line held low 20000 cycles, then a valid 0x55 frame -> one frame_err pulse, no delivery of 0x3C; dout=8'h55 delivered.
- REQ-031: Frames 0x11 then 0x22 with no ack -> dout=8'h11, overrun=1; ack -> overrun=0, dout_valid=0.
- REQ-032: Reset asserted during data bit 4 of 0xFF -> no dout_valid; the following frame 0x0F -> dout=8'h0F.
- REQ-033: With UART_RX_MAJORITY_EN, a 1-cycle low glitch at the mid point of bit 0 of 0x01 -> dout=8'h01; without the macro -> dout=8'h00.
